det_window_counter: RTL

Counts detection pulses from the non-overlapping Mealy sequence detector over fixed windows of valid input bits. Sits directly downstream of the detector: it samples `det` on each valid bit slot. At every window boundary it publishes the per-window hit count through a valid/ready output register for the host or statistics logic.

---
 rtl/det_cnt_pkg.sv | 29 ++
 rtl/det_window_counter_if.sv | 37 +++
 rtl/det_sat_acc.sv | 51 +++++
 rtl/det_window_counter.sv | 102 ++++++++++
 4 files changed

// File: rtl/det_cnt_pkg.sv
// Shared types, defaults and the saturating-increment helper for the
// detection window counter.
package det_cnt_pkg;

    // Output register occupancy
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_st_e;

    localparam int DET_CNT_W_DEF   = 8;
    localparam int DET_WIN_LEN_DEF = 16;

    // Working width of sat_inc; counters narrower than this are padded
    // with ones above their MSB so that "all ones" marks saturation.
    localparam int DET_SAT_W = 32;

    // Add one when en is set, unless value is already all ones.
    function automatic logic [DET_SAT_W-1:0] sat_inc(
        input logic [DET_SAT_W-1:0] value,
        input logic                 en
    );
        if (en && (value != '1))
            return value + DET_SAT_W'(1);
        else
            return value;
    endfunction

endpackage

// File: rtl/det_window_counter_if.sv
// Bit-slot input, windowed result handshake and status of the detection
// window counter. Threshold/alarm signals exist only with DET_CNT_THRESH_EN.
interface det_window_counter_if #(
    parameter int CNT_W = 8
);
    logic             bit_vld;
    logic             det;
    logic [CNT_W-1:0] win_cnt;
    logic             win_valid;
    logic             win_ready;
    logic             overrun;
`ifdef DET_CNT_THRESH_EN
    logic [CNT_W-1:0] thresh;
    logic             alarm;
`endif

`ifdef DET_CNT_THRESH_EN
    modport master (
        output bit_vld, det, win_ready, thresh,
        input  win_cnt, win_valid, overrun, alarm
    );
    modport slave (
        input  bit_vld, det, win_ready, thresh,
        output win_cnt, win_valid, overrun, alarm
    );
`else
    modport master (
        output bit_vld, det, win_ready,
        input  win_cnt, win_valid, overrun
    );
    modport slave (
        input  bit_vld, det, win_ready,
        output win_cnt, win_valid, overrun
    );
`endif

endinterface

// File: rtl/det_sat_acc.sv
// Saturating hit accumulator and slot index for one counting window.
// win_end flags the last valid slot of a window; result is the window's
// hit count including that final slot's hit.
module det_sat_acc
    import det_cnt_pkg::*;
#(
    parameter int WIN_LEN = DET_WIN_LEN_DEF,
    parameter int CNT_W   = DET_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             det,
    output logic             win_end,
    output logic [CNT_W-1:0] result
);

    localparam int SLOT_W = $clog2(WIN_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WIN_LEN - 1);

    // Accumulator kept at the helper's full width: the bits above CNT_W are
    // held at one, so the helper saturates exactly at 2^CNT_W-1 and synthesis
    // folds those constant bits away.
    localparam logic [DET_SAT_W-1:0] ACC_CLR =
        {{(DET_SAT_W - CNT_W){1'b1}}, {CNT_W{1'b0}}};

    logic [SLOT_W-1:0]    slot_idx;
    logic [DET_SAT_W-1:0] acc;
    logic [DET_SAT_W-1:0] acc_nxt;

    assign win_end = bit_vld && (slot_idx == SLOT_LAST);
    assign acc_nxt = sat_inc(acc, bit_vld & det);
    assign result  = acc_nxt[CNT_W-1:0];

    // Advance slot index and accumulate on valid slots; clear at window end
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_idx <= '0;
            acc      <= ACC_CLR;
        end else if (bit_vld) begin
            if (win_end) begin
                slot_idx <= '0;
                acc      <= ACC_CLR;
            end else begin
                slot_idx <= slot_idx + SLOT_W'(1);
                acc      <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/det_window_counter.sv
// Per-window hit counter downstream of the sequence detector. Each window
// result lands in a one-deep valid/ready output register; a result arriving
// while that register is still occupied is dropped and flags overrun.
// Optional feature macro: DET_CNT_THRESH_EN adds thresh/alarm.
module det_window_counter
    import det_cnt_pkg::*;
#(
    parameter int WIN_LEN = DET_WIN_LEN_DEF,
    parameter int CNT_W   = DET_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    det_window_counter_if.slave  bus
);

    logic             win_end;
    logic [CNT_W-1:0] result;

    out_st_e          state;
    out_st_e          state_nxt;
    logic             load_en;
    logic             drop_en;

    logic [CNT_W-1:0] win_cnt_p1;
    logic             overrun_p1;

    det_sat_acc #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .bit_vld (bus.bit_vld),
        .det     (bus.det),
        .win_end (win_end),
        .result  (result)
    );

    // Output register occupancy state
    always_ff @(posedge clk) begin
        if (rst)
            state <= OUT_EMPTY;
        else
            state <= state_nxt;
    end

    // Fill on window end, drain on accept; accept plus window end stays full
    always_comb begin
        state_nxt = state;
        case (state)
            OUT_EMPTY: if (win_end) state_nxt = OUT_FULL;
            OUT_FULL:  if (bus.win_ready && !win_end) state_nxt = OUT_EMPTY;
            default:   state_nxt = OUT_EMPTY;
        endcase
    end

    // Decide whether this window's result is loaded or dropped
    always_comb begin
        load_en = 1'b0;
        drop_en = 1'b0;
        case (state)
            OUT_EMPTY: load_en = win_end;
            OUT_FULL: begin
                load_en = win_end && bus.win_ready;
                drop_en = win_end && !bus.win_ready;
            end
            default: ;
        endcase
    end

    // Result register and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_p1 <= '0;
            overrun_p1 <= 1'b0;
        end else begin
            if (load_en)
                win_cnt_p1 <= result;
            if (drop_en)
                overrun_p1 <= 1'b1;
        end
    end

    assign bus.win_cnt   = win_cnt_p1;
    assign bus.win_valid = (state == OUT_FULL);
    assign bus.overrun   = overrun_p1;

`ifdef DET_CNT_THRESH_EN
    logic alarm_p1;

    // Threshold compare captured alongside each result load
    always_ff @(posedge clk) begin
        if (rst)
            alarm_p1 <= 1'b0;
        else if (load_en)
            alarm_p1 <= (result >= bus.thresh);
    end

    assign bus.alarm = alarm_p1;
`endif

endmodule
